sva_verdict_collector: RTL

Downstream result stage for the generated SVA checker FSMs. Samples the per-attempt `succ`, `fail` and `lazy_succ` flags on the user clock and keeps saturating pass, fail, lazy and cycle counters. Timestamps of failures are buffered in a small FIFO for host readout. A run/drain/done state machine produces the final test verdict.

---
 rtl/sva_verdict_collector.sv | 134 +++++++++++++
 1 files changed

// File: rtl/sva_verdict_collector.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | sva_verdict_collector: counts SVA checker outcomes, buffers failure         |
// | timestamps, and produces the final run verdict.  Rev 1.0                    |
// +-----------------------------------------------------------------------------+
module sva_verdict_collector #(
  parameter int CNT_WIDTH  = 16,
  parameter int FAIL_DEPTH = 4,
  parameter int MAX_FAIL   = 0,
  parameter int DRAIN_CYC  = 2
) (
  input  logic                 gclk,
  input  logic                 grst,
  input  logic                 start_i,
  input  logic                 end_i,
  input  logic                 succ_i,
  input  logic                 fail_i,
  input  logic                 lazy_i,
  output logic [CNT_WIDTH-1:0] pass_cnt_o,
  output logic [CNT_WIDTH-1:0] fail_cnt_o,
  output logic [CNT_WIDTH-1:0] lazy_cnt_o,
  output logic [CNT_WIDTH-1:0] cyc_cnt_o,
  output logic                 fts_valid_o,
  output logic [CNT_WIDTH-1:0] fts_data_o,
  input  logic                 fts_ready_i,
  output logic                 fts_ovf_o,
  output logic                 done_o,
  output logic                 pass_o,
  output logic                 abort_o
);

  localparam int AW = $clog2(FAIL_DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                 state, state_nxt;
  logic [CNT_WIDTH-1:0]   pass_cnt, fail_cnt, lazy_cnt, cyc_cnt;
  logic [CNT_WIDTH-1:0]   fail_nxt;
  logic [7:0]             drain_tmr;
  logic                   aborted;
  logic                   ovf;
  logic [PW-1:0]          wr_ptr, rd_ptr;
  logic [CNT_WIDTH-1:0]   mem [FAIL_DEPTH];
  logic                   active, launch, empty, full, pop, push, push_ok, abort_hit;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v,
                                                   input logic en);
    return (en && (v != '1)) ? v + CNT_WIDTH'(1) : v;
  endfunction

  assign active    = (state == RUN) || (state == DRAIN);
  assign launch    = start_i && ((state == IDLE) || (state == DONE));
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign pop       = !empty && fts_ready_i;
  assign push      = active && fail_i;
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign push_ok   = push && (!full || pop);
  assign fail_nxt  = sat_inc(fail_cnt, fail_i);
  assign abort_hit = active && fail_i && (MAX_FAIL != 0) &&
                     (fail_nxt == CNT_WIDTH'(MAX_FAIL));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start_i) state_nxt = RUN;
      RUN: begin
        if (abort_hit)  state_nxt = DONE;
        else if (end_i) state_nxt = DRAIN;
      end
      DRAIN: if (abort_hit || (drain_tmr == 8'd1)) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge gclk or posedge grst) begin
    if (grst) begin
      state     <= IDLE;
      pass_cnt  <= '0;
      fail_cnt  <= '0;
      lazy_cnt  <= '0;
      cyc_cnt   <= '0;
      drain_tmr <= '0;
      aborted   <= 1'b0;
      ovf       <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
    end else begin
      state <= state_nxt;
      if (launch) begin
        pass_cnt <= '0;
        fail_cnt <= '0;
        lazy_cnt <= '0;
        cyc_cnt  <= '0;
        aborted  <= 1'b0;
        ovf      <= 1'b0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
      end else begin
        if (active) begin
          pass_cnt <= sat_inc(pass_cnt, succ_i);
          fail_cnt <= fail_nxt;
          lazy_cnt <= sat_inc(lazy_cnt, lazy_i);
          cyc_cnt  <= sat_inc(cyc_cnt, 1'b1);
        end
        if (push && !push_ok) ovf <= 1'b1;
        if (abort_hit)        aborted <= 1'b1;
        if (pop)              rd_ptr <= rd_ptr + PW'(1);
        if (push_ok)          wr_ptr <= wr_ptr + PW'(1);
      end
      if ((state == RUN) && end_i) drain_tmr <= 8'(DRAIN_CYC);
      else if (state == DRAIN)     drain_tmr <= drain_tmr - 8'd1;
    end
  end

  // Timestamp storage needs no reset; the output is masked while empty.
  always_ff @(posedge gclk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= cyc_cnt;
  end

  assign pass_cnt_o  = pass_cnt;
  assign fail_cnt_o  = fail_cnt;
  assign lazy_cnt_o  = lazy_cnt;
  assign cyc_cnt_o   = cyc_cnt;
  assign fts_valid_o = !empty;
  assign fts_data_o  = empty ? '0 : mem[rd_ptr[AW-1:0]];
  assign fts_ovf_o   = ovf;
  assign done_o      = (state == DONE);
  assign abort_o     = aborted;
  assign pass_o      = done_o && (fail_cnt == '0) && (pass_cnt != '0) && !aborted;

endmodule
`default_nettype wire
